// File: rtl/deploy_ctrl.sv
// deploy_ctrl: card-deploy controller (select a card slot by clicking its
// hitbox, release the button inside the deploy zone to spend elixir, wait
// while the unit is on the field, then an optional cooldown).
//
// Ports:
//   Clk, Reset        sole clock (rising edge), synchronous active-low reset
//   click             mouse button code: 0 none, 1 left, 2 right, 3 both,
//                     4..15 behave like 0
//   X, Y              cursor position
//   box_lx/ly/ux/uy   packed inclusive per-slot hitboxes, slot i at [i*CW +: CW]
//   cost              packed per-slot elixir cost, slot i at [i*EW +: EW]
//   eli               current elixir pool
//   infield           per-slot "unit alive on the field" flags
//   idle/instate/deploy/cooling  one-hot-ish state indicators
//   elixirin          elixir to spend, nonzero only in DEPLOY
//   sel_slot          latched selected slot
//   deploy_x/y        cursor latched on ARMED->DEPLOY
//   short             release in zone refused for lack of elixir (combinational)
//
// Configuration macro: DEPLOY_CTRL_COOLDOWN_EN
//   defined   -> INFIELD is followed by a COOLDOWN_CYC-cycle COOLDOWN state
//   undefined -> INFIELD returns straight to IDLE, cooling is tied low

module deploy_ctrl #(
  parameter int N_SLOTS      = 4,
  parameter int CW           = 10,
  parameter int EW           = 5,
  parameter int ZONE_XMIN    = 300,
  parameter int ZONE_XMAX    = 500,
  parameter int COOLDOWN_CYC = 60
) (
  input  logic                        Clk,
  input  logic                        Reset,
  input  logic [3:0]                  click,
  input  logic [CW-1:0]               X,
  input  logic [CW-1:0]               Y,
  input  logic [N_SLOTS*CW-1:0]       box_lx,
  input  logic [N_SLOTS*CW-1:0]       box_ly,
  input  logic [N_SLOTS*CW-1:0]       box_ux,
  input  logic [N_SLOTS*CW-1:0]       box_uy,
  input  logic [N_SLOTS*EW-1:0]       cost,
  input  logic [EW-1:0]               eli,
  input  logic [N_SLOTS-1:0]          infield,
  output logic                        idle,
  output logic                        instate,
  output logic                        deploy,
  output logic [EW-1:0]               elixirin,
  output logic [$clog2(N_SLOTS)-1:0]  sel_slot,
  output logic [CW-1:0]               deploy_x,
  output logic [CW-1:0]               deploy_y,
  output logic                        short,
  output logic                        cooling
);

  localparam int SW = $clog2(N_SLOTS);
  localparam logic [CW-1:0] ZMIN = CW'(ZONE_XMIN);
  localparam logic [CW-1:0] ZMAX = CW'(ZONE_XMAX);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_ARMED    = 3'd1,
    ST_DEPLOY   = 3'd2,
    ST_INFIELD  = 3'd3,
    ST_COOLDOWN = 3'd4
  } state_t;

  state_t state, state_nxt;

  // ---------------------------------------------------------------------
  // Hitbox decode and lowest-index priority
  // ---------------------------------------------------------------------
  logic [N_SLOTS-1:0] hit;
  logic               any_hit;
  logic [SW-1:0]      hit_idx;
  logic               hit_free;   // lowest hit exists and its unit is not on the field

  always_comb begin
    for (int i = 0; i < N_SLOTS; i++) begin
      hit[i] = (X >= box_lx[i*CW +: CW]) && (X <= box_ux[i*CW +: CW]) &&
               (Y >= box_ly[i*CW +: CW]) && (Y <= box_uy[i*CW +: CW]);
    end
  end

  // Scan from the top down so the last write wins with the lowest index.
  always_comb begin
    any_hit = 1'b0;
    hit_idx = '0;
    for (int i = N_SLOTS - 1; i >= 0; i--) begin
      if (hit[i]) begin
        any_hit = 1'b1;
        hit_idx = SW'(i);
      end
    end
  end

  assign hit_free = any_hit && !infield[hit_idx];

  // ---------------------------------------------------------------------
  // Click decode, zone and affordability
  // ---------------------------------------------------------------------
  logic          click_left;
  logic          click_cancel;
  logic          click_release;   // includes the unused codes 4..15
  logic          in_zone;
  logic [EW-1:0] sel_cost;
  logic          afford;

  assign click_left    = (click == 4'd1);
  assign click_cancel  = (click == 4'd2) || (click == 4'd3);
  assign click_release = !click_left && !click_cancel;
  assign in_zone       = (X >= ZMIN) && (X <= ZMAX);
  assign sel_cost      = cost[int'(sel_slot)*EW +: EW];
  assign afford        = (eli >= sel_cost);

  // ---------------------------------------------------------------------
  // Cooldown counter (optional)
  // ---------------------------------------------------------------------
`ifdef DEPLOY_CTRL_COOLDOWN_EN
  localparam int CNT_W = (COOLDOWN_CYC > 1) ? $clog2(COOLDOWN_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(COOLDOWN_CYC - 1);

  logic [CNT_W-1:0] cd_cnt;
  logic             cd_done;

  assign cd_done = (cd_cnt == '0);

  // Loads on entry so the value read in the first COOLDOWN cycle is
  // COOLDOWN_CYC-1; the state exits on the cycle it reads zero.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      cd_cnt <= '0;
    end else if (state == ST_INFIELD && state_nxt == ST_COOLDOWN) begin
      cd_cnt <= CNT_LOAD;
    end else if (state == ST_COOLDOWN && !cd_done) begin
      cd_cnt <= cd_cnt - 1'b1;
    end
  end
`endif

  // ---------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // ---------------------------------------------------------------------
  // FSM: next-state logic plus load enables for the latched outputs
  // ---------------------------------------------------------------------
  logic          sel_ld;
  logic [SW-1:0] sel_nxt;
  logic          pos_ld;

  always_comb begin
    state_nxt = state;
    sel_ld    = 1'b0;
    sel_nxt   = sel_slot;
    pos_ld    = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (click_left && hit_free) begin
          state_nxt = ST_ARMED;
          sel_ld    = 1'b1;
          sel_nxt   = hit_idx;
        end
      end
      ST_ARMED: begin
        if (click_cancel) begin
          state_nxt = ST_IDLE;
        end else if (click_left) begin
          // Re-select only when the lowest hit is a different, free slot.
          if (hit_free && hit_idx != sel_slot) begin
            sel_ld  = 1'b1;
            sel_nxt = hit_idx;
          end
        end else if (in_zone && afford) begin
          state_nxt = ST_DEPLOY;
          pos_ld    = 1'b1;
        end
      end
      ST_DEPLOY: begin
        state_nxt = ST_INFIELD;
      end
      ST_INFIELD: begin
        if (!infield[sel_slot]) begin
`ifdef DEPLOY_CTRL_COOLDOWN_EN
          state_nxt = ST_COOLDOWN;
`else
          state_nxt = ST_IDLE;
`endif
        end
      end
      ST_COOLDOWN: begin
`ifdef DEPLOY_CTRL_COOLDOWN_EN
        if (cd_done) begin
          state_nxt = ST_IDLE;
        end
`else
        state_nxt = ST_IDLE;
`endif
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // Latched selection and deploy position; these hold everywhere else.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      sel_slot <= '0;
      deploy_x <= '0;
      deploy_y <= '0;
    end else begin
      if (sel_ld) begin
        sel_slot <= sel_nxt;
      end
      if (pos_ld) begin
        deploy_x <= X;
        deploy_y <= Y;
      end
    end
  end

  // ---------------------------------------------------------------------
  // FSM: output decode
  // ---------------------------------------------------------------------
  always_comb begin
    idle     = (state == ST_IDLE);
    instate  = (state == ST_ARMED);
    deploy   = (state == ST_DEPLOY);
    elixirin = (state == ST_DEPLOY) ? sel_cost : '0;
    short    = (state == ST_ARMED) && click_release && in_zone && !afford;
`ifdef DEPLOY_CTRL_COOLDOWN_EN
    cooling  = (state == ST_COOLDOWN);
`else
    cooling  = 1'b0;
`endif
  end

endmodule

// File: tb/tb_deploy_ctrl.sv
// Testbench for deploy_ctrl: directed vector table, hand-written cooldown
// sequence, and randomized traffic against a behavioural model.
module tb_deploy_ctrl;

  localparam int NS = 4;
  localparam int CW = 10;
  localparam int EW = 5;
  localparam int CD = 5;

  logic              Clk;
  logic              Reset;
  logic [3:0]        click;
  logic [CW-1:0]     X, Y;
  logic [NS*CW-1:0]  box_lx, box_ly, box_ux, box_uy;
  logic [NS*EW-1:0]  cost;
  logic [EW-1:0]     eli;
  logic [NS-1:0]     infield;
  logic              idle, instate, deploy, short, cooling;
  logic [EW-1:0]     elixirin;
  logic [1:0]        sel_slot;
  logic [CW-1:0]     deploy_x, deploy_y;

  deploy_ctrl #(
    .N_SLOTS(NS), .CW(CW), .EW(EW),
    .ZONE_XMIN(300), .ZONE_XMAX(500), .COOLDOWN_CYC(CD)
  ) dut (
    .Clk(Clk), .Reset(Reset), .click(click), .X(X), .Y(Y),
    .box_lx(box_lx), .box_ly(box_ly), .box_ux(box_ux), .box_uy(box_uy),
    .cost(cost), .eli(eli), .infield(infield),
    .idle(idle), .instate(instate), .deploy(deploy), .elixirin(elixirin),
    .sel_slot(sel_slot), .deploy_x(deploy_x), .deploy_y(deploy_y),
    .short(short), .cooling(cooling)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  // Slot geometry: slots 1 and 2 overlap around X=10.
  int bx_lo[NS] = '{100,   0,   5, 200};
  int bx_hi[NS] = '{149,  20,  30, 249};
  int by_lo[NS] = '{  0, 100, 100,   0};
  int by_hi[NS] = '{ 49, 149, 149,  49};
  int cst[NS]   = '{  3,   9,   6,   2};

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  typedef enum int {M_IDLE, M_ARMED, M_DEPLOY, M_INFIELD, M_COOL} mstate_t;
  mstate_t m_state;
  int m_sel, m_dx, m_dy, m_left;

  function automatic int lowest_hit(input int x, input int y);
    for (int i = 0; i < NS; i++)
      if (x >= bx_lo[i] && x <= bx_hi[i] && y >= by_lo[i] && y <= by_hi[i]) return i;
    return -1;
  endfunction

  function automatic bit is_release(input int c);
    return (c == 0) || (c > 3);
  endfunction

  // Advance the model by one clock edge using the inputs currently applied.
  task automatic model_step();
    int h, c, x, y, e;
    c = int'(click); x = int'(X); y = int'(Y); e = int'(eli);
    h = lowest_hit(x, y);
    if (!Reset) begin
      m_state = M_IDLE; m_sel = 0; m_dx = 0; m_dy = 0; m_left = 0;
      return;
    end
    case (m_state)
      M_IDLE:
        if (c == 1 && h >= 0 && !infield[h]) begin m_state = M_ARMED; m_sel = h; end
      M_ARMED:
        if (c == 2 || c == 3) m_state = M_IDLE;
        else if (c == 1) begin
          if (h >= 0 && h != m_sel && !infield[h]) m_sel = h;
        end else if (x >= 300 && x <= 500 && e >= cst[m_sel]) begin
          m_state = M_DEPLOY; m_dx = x; m_dy = y;
        end
      M_DEPLOY: m_state = M_INFIELD;
      M_INFIELD:
        if (!infield[m_sel]) begin
`ifdef DEPLOY_CTRL_COOLDOWN_EN
          m_state = M_COOL; m_left = CD;
`else
          m_state = M_IDLE;
`endif
        end
      M_COOL: begin
        m_left--;
        if (m_left == 0) m_state = M_IDLE;
      end
      default: m_state = M_IDLE;
    endcase
  endtask

  task automatic compare_model();
    bit sh;
    sh = (m_state == M_ARMED) && is_release(int'(click)) &&
         (int'(X) >= 300) && (int'(X) <= 500) && (int'(eli) < cst[m_sel]);
    chk("rnd_idle",     32'(idle),     32'(m_state == M_IDLE));
    chk("rnd_instate",  32'(instate),  32'(m_state == M_ARMED));
    chk("rnd_deploy",   32'(deploy),   32'(m_state == M_DEPLOY));
    chk("rnd_cooling",  32'(cooling),  32'(m_state == M_COOL));
    chk("rnd_elixirin", 32'(elixirin), (m_state == M_DEPLOY) ? 32'(cst[m_sel]) : 32'd0);
    chk("rnd_sel",      32'(sel_slot), 32'(m_sel));
    chk("rnd_dx",       32'(deploy_x), 32'(m_dx));
    chk("rnd_dy",       32'(deploy_y), 32'(m_dy));
    chk("rnd_short",    32'(short),    32'(sh));
  endtask

  // ---------------- directed vectors ----------------
  // Expected values are the outputs seen with this row's inputs applied,
  // before the clock edge that consumes them.
  typedef struct {
    bit rst_n; int clk_code; int x; int y; int e; int inf;
    int e_idle; int e_inst; int e_dep; int e_elx; int e_sel; int e_dx; int e_short;
  } vec_t;

  vec_t tbl[$];

  task automatic drive(input bit r, input int c, input int x, input int y, input int e, input int inf);
    Reset = r; click = 4'(c); X = CW'(x); Y = CW'(y); eli = EW'(e); infield = NS'(inf);
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  int n;
  int r;
  int s;

  initial begin
    for (int i = 0; i < NS; i++) begin
      box_lx[i*CW +: CW] = CW'(bx_lo[i]);
      box_ux[i*CW +: CW] = CW'(bx_hi[i]);
      box_ly[i*CW +: CW] = CW'(by_lo[i]);
      box_uy[i*CW +: CW] = CW'(by_hi[i]);
      cost[i*EW +: EW]   = EW'(cst[i]);
    end

    //               rst c   x    y   e  inf  idl ins dep elx sel dx  sh
    tbl.push_back('{1, 1,  25, 120, 8, 0,  1,  0,  0,  0,  0,  0,  0}); // click slot 2
    tbl.push_back('{1, 0, 400,   7, 8, 0,  0,  1,  0,  0,  2,  0,  0}); // release in zone
    tbl.push_back('{1, 0,   0,   0, 8, 4,  0,  0,  1,  6,  2, 400, 0}); // DEPLOY cycle
    tbl.push_back('{1, 0,   0,   0, 8, 4,  0,  0,  0,  0,  2, 400, 0}); // INFIELD holds
    tbl.push_back('{0, 0,   0,   0, 8, 4,  0,  0,  0,  0,  2, 400, 0}); // reset in INFIELD
    tbl.push_back('{1, 1,  25, 120, 8, 4,  1,  0,  0,  0,  0,  0,  0}); // slot 2 on field: ignored
    tbl.push_back('{1, 1, 120,  20, 8, 4,  1,  0,  0,  0,  0,  0,  0}); // arm slot 0
    tbl.push_back('{1, 1, 220,  20, 8, 4,  0,  1,  0,  0,  0,  0,  0}); // re-select slot 3
    tbl.push_back('{1, 2,   0,   0, 8, 4,  0,  1,  0,  0,  3,  0,  0}); // cancel
    tbl.push_back('{1, 1,  10, 120, 8, 0,  1,  0,  0,  0,  3,  0,  0}); // overlap 1/2 -> 1
    tbl.push_back('{1, 0, 350,   9, 4, 0,  0,  1,  0,  0,  1,  0,  1}); // short
    tbl.push_back('{1, 0, 350,   9, 9, 0,  0,  1,  0,  0,  1,  0,  0}); // enough elixir
    tbl.push_back('{1, 0,   0,   0, 9, 2,  0,  0,  1,  9,  1, 350, 0}); // DEPLOY slot 1
    tbl.push_back('{0, 0,   0,   0, 9, 2,  0,  0,  0,  0,  1, 350, 0}); // reset in INFIELD
    tbl.push_back('{1, 1, 120,  20, 9, 0,  1,  0,  0,  0,  0,  0,  0}); // arm slot 0
    tbl.push_back('{1, 5, 300,   3, 1, 0,  0,  1,  0,  0,  0,  0,  1}); // code 5 = release, X=min
    tbl.push_back('{1, 0, 501,   3, 1, 0,  0,  1,  0,  0,  0,  0,  0}); // just outside
    tbl.push_back('{1, 0, 299,   3, 1, 0,  0,  1,  0,  0,  0,  0,  0}); // just outside
    tbl.push_back('{1, 0, 500,   3, 2, 0,  0,  1,  0,  0,  0,  0,  1}); // X=max, short
    tbl.push_back('{1, 0, 500,   3, 3, 0,  0,  1,  0,  0,  0,  0,  0}); // eli == cost deploys
    tbl.push_back('{1, 3,   0,   0, 3, 0,  0,  0,  1,  3,  0, 500, 0}); // clicks ignored in DEPLOY
    tbl.push_back('{1, 0,   0,   0, 3, 1,  0,  0,  0,  0,  0, 500, 0}); // INFIELD holds
    tbl.push_back('{0, 0,   0,   0, 3, 0,  0,  0,  0,  0,  0, 500, 0}); // reset
    tbl.push_back('{1, 0,   0,   0, 3, 0,  1,  0,  0,  0,  0,  0,  0}); // back in IDLE

    // Reset for two cycles
    drive(0, 0, 0, 0, 0, 0);
    tick();
    tick();
    chk("rst_idle",     32'(idle),     32'd1);
    chk("rst_sel",      32'(sel_slot), 32'd0);
    chk("rst_deploy",   32'(deploy),   32'd0);
    chk("rst_elixirin", 32'(elixirin), 32'd0);
    chk("rst_instate",  32'(instate),  32'd0);
    chk("rst_cooling",  32'(cooling),  32'd0);
    chk("rst_dx",       32'(deploy_x), 32'd0);

    foreach (tbl[i]) begin
      drive(tbl[i].rst_n, tbl[i].clk_code, tbl[i].x, tbl[i].y, tbl[i].e, tbl[i].inf);
      #1;
      chk($sformatf("vec%0d_idle", i),     32'(idle),     32'(tbl[i].e_idle));
      chk($sformatf("vec%0d_instate", i),  32'(instate),  32'(tbl[i].e_inst));
      chk($sformatf("vec%0d_deploy", i),   32'(deploy),   32'(tbl[i].e_dep));
      chk($sformatf("vec%0d_elixirin", i), 32'(elixirin), 32'(tbl[i].e_elx));
      chk($sformatf("vec%0d_sel", i),      32'(sel_slot), 32'(tbl[i].e_sel));
      chk($sformatf("vec%0d_dx", i),       32'(deploy_x), 32'(tbl[i].e_dx));
      chk($sformatf("vec%0d_short", i),    32'(short),    32'(tbl[i].e_short));
      chk($sformatf("vec%0d_cooling", i),  32'(cooling),  32'd0);
      tick();
    end

    // Deploy, then drop the unit off the field and time the cooldown.
    drive(1, 1, 120, 20, 9, 0);
    tick();
    drive(1, 0, 400, 30, 9, 0);
    tick();
    chk("cd_in_deploy", 32'(deploy), 32'd1);
    drive(1, 0, 0, 0, 9, 1);
    tick();
    drive(1, 0, 0, 0, 9, 0);
    tick();
`ifdef DEPLOY_CTRL_COOLDOWN_EN
    n = 0;
    while (cooling && n < 20) begin
      n++;
      tick();
    end
    chk("cd_length", 32'(n), 32'(CD));
    chk("cd_then_idle", 32'(idle), 32'd1);
`else
    chk("nocd_idle", 32'(idle), 32'd1);
    chk("nocd_cooling", 32'(cooling), 32'd0);
`endif

    // Randomized traffic against the model
    drive(0, 0, 0, 0, 0, 0);
    model_step();
    tick();
    for (int k = 0; k < 3000; k++) begin
      r = int'($urandom_range(0, 9));
      if (r <= 3) click = 4'd0;
      else if (r <= 6) click = 4'd1;
      else if (r == 7) click = 4'd2;
      else if (r == 8) click = 4'd3;
      else click = 4'($urandom_range(4, 15));
      if ($urandom_range(0, 1) == 0) begin
        s = int'($urandom_range(0, NS - 1));
        X = CW'($urandom_range(bx_lo[s], bx_hi[s]));
        Y = CW'($urandom_range(by_lo[s], by_hi[s]));
      end else begin
        X = CW'($urandom_range(250, 560));
        Y = CW'($urandom_range(0, 160));
      end
      eli     = EW'($urandom_range(0, 31));
      infield = NS'($urandom);
      Reset   = ($urandom_range(0, 99) == 0) ? 1'b0 : 1'b1;
      #1;
      compare_model();
      model_step();
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
